// File: rtl/timer_ctr.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers on the CPU data bus,
// one-shot or auto-reload countdown with a maskable expiry interrupt.
module timer_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IM = 3;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic ctrl_wr;
  logic preset_wr;
  logic auto_reload;
  logic expire;

  // MODE 01 is the only auto-reload encoding; 00 and 1x are one-shot.
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign ctrl_wr     = WE && (Addr == A_CTRL);
  assign preset_wr   = WE && (Addr == A_PRESET);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    expire     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          expire  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
          state_d    = LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A CTRL write overrides the automatic EN clear and clears the flag,
    // but an expiry on the same edge still sets the flag.
    if (ctrl_wr) begin
      ctrl_d     = Din[3:0];
      irq_flag_d = 1'b0;
    end
    if (preset_wr) preset_d = Din;
    if (expire)    irq_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    case (Addr)
      A_CTRL:   Dout = {28'd0, ctrl_q};
      A_PRESET: Dout = preset_q;
      A_COUNT:  Dout = count_q;
      default:  Dout = 32'd0;
    endcase
  end

  assign IRQ = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_ctr.sv
// Bench for timer_ctr: directed scenarios plus randomized bus traffic checked
// against a behavioural model of the timer.
module tb_timer_ctr;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int tests_run;
  int tests_failed;

  timer_ctr dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model state: phases 0 idle, 1 load, 2 counting, 3 expired.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  int          m_phase;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    WE   = 1'b1;
    Din  = d;
    @(posedge clk);
    #1;
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic apply_reset();
    WE    = 1'b0;
    Addr  = 2'd0;
    Din   = 32'd0;
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic model_reset();
    m_ctrl   = 4'd0;
    m_preset = 32'd0;
    m_count  = 32'd0;
    m_flag   = 1'b0;
    m_phase  = 0;
  endtask

  task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] d);
    logic [3:0]  nctrl;
    logic [31:0] npreset;
    logic [31:0] ncount;
    logic        nflag;
    int          nphase;
    bit          expired;
    nctrl   = m_ctrl;
    npreset = m_preset;
    ncount  = m_count;
    nflag   = m_flag;
    nphase  = m_phase;
    expired = 0;
    if (m_phase == 0) begin
      if (m_ctrl[0]) nphase = 1;
    end else if (m_phase == 1) begin
      ncount = m_preset;
      nphase = 2;
    end else if (m_phase == 2) begin
      if (!m_ctrl[0]) nphase = 0;
      else if (m_count > 1) ncount = m_count - 1;
      else begin
        ncount  = 0;
        expired = 1;
        nphase  = 3;
      end
    end else begin
      if (m_ctrl[2:1] == 2'b01) begin
        nflag  = 0;
        nphase = 1;
      end else begin
        nctrl[0] = 1'b0;
        nphase   = 0;
      end
    end
    if (we && a == 2'd0) begin
      nctrl = d[3:0];
      nflag = 0;
    end
    if (we && a == 2'd1) npreset = d;
    if (expired) nflag = 1;
    m_ctrl   = nctrl;
    m_preset = npreset;
    m_count  = ncount;
    m_flag   = nflag;
    m_phase  = nphase;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    apply_reset();
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      tests_run++;
      if (d !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_dout[%0d]: got %h expected %h", a, d, 32'd0);
      end
    end
    tests_run++;
    if (IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_irq: got %b expected 0", IRQ);
    end
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h9);
    repeat (5) tick();
    rd(2'd2, d);
    tests_run++;
    if (d !== 32'd5) begin
      tests_failed++;
      $display("FAIL midcount_before_reset: got %0d expected 5", d);
    end
    #1;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      tests_run++;
      if (d !== 32'd0) begin
        tests_failed++;
        $display("FAIL async_reset_dout[%0d]: got %h expected %h", a, d, 32'd0);
      end
    end
    tests_run++;
    if (IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_irq: got %b expected 0", IRQ);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    apply_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    tick();
    tick();
    rd(2'd2, d);
    tests_run++;
    if (d !== 32'd3) begin
      tests_failed++;
      $display("FAIL oneshot_count_e2: got %0d expected 3", d);
    end
    tick();
    tick();
    rd(2'd2, d);
    tests_run++;
    if (d !== 32'd1 || IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL oneshot_e4: got count %0d irq %b expected count 1 irq 0", d, IRQ);
    end
    tick();
    rd(2'd2, d);
    tests_run++;
    if (d !== 32'd0 || IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL oneshot_e5: got count %0d irq %b expected count 0 irq 1", d, IRQ);
    end
    tick();
    rd(2'd0, d);
    tests_run++;
    if (d !== 32'h8) begin
      tests_failed++;
      $display("FAIL oneshot_ctrl_e6: got %h expected %h", d, 32'h8);
    end
    repeat (4) tick();
    tests_run++;
    if (IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL oneshot_irq_held: got %b expected 1", IRQ);
    end
    wr(2'd0, 32'h8);
    tests_run++;
    if (IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL oneshot_irq_cleared: got %b expected 0", IRQ);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    logic        exp_irq;
    logic [31:0] exp_cnt;
    apply_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int c = 1; c <= 13; c++) begin
      tick();
      exp_irq = (c == 4 || c == 8 || c == 12);
      tests_run++;
      if (IRQ !== exp_irq) begin
        tests_failed++;
        $display("FAIL autoreload_irq_e%0d: got %b expected %b", c, IRQ, exp_irq);
      end
      if (c >= 2) begin
        case ((c - 2) % 4)
          0: exp_cnt = 32'd2;
          1: exp_cnt = 32'd1;
          default: exp_cnt = 32'd0;
        endcase
        rd(2'd2, d);
        tests_run++;
        if (d !== exp_cnt) begin
          tests_failed++;
          $display("FAIL autoreload_count_e%0d: got %0d expected %0d", c, d, exp_cnt);
        end
      end
    end
    wr(2'd0, 32'h0);
  endtask

  task automatic test_mask_off();
    logic [31:0] d;
    apply_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      tests_run++;
      if (IRQ !== 1'b0) begin
        tests_failed++;
        $display("FAIL maskoff_irq_e%0d: got %b expected 0", c, IRQ);
      end
    end
    rd(2'd0, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL maskoff_en_cleared: got %h expected %h", d, 32'h0);
    end
    wr(2'd0, 32'h8);
    tests_run++;
    if (IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL maskoff_after_im_write: got %b expected 0", IRQ);
    end
  endtask

  task automatic test_midcount();
    logic [31:0] d;
    apply_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    repeat (6) tick();
    rd(2'd2, d);
    tests_run++;
    if (d !== 32'd6) begin
      tests_failed++;
      $display("FAIL midcount_e6: got %0d expected 6", d);
    end
    wr(2'd1, 32'd2);
    rd(2'd2, d);
    tests_run++;
    if (d !== 32'd5) begin
      tests_failed++;
      $display("FAIL midcount_preset_ignored: got %0d expected 5", d);
    end
    tick();
    tick();
    rd(2'd2, d);
    tests_run++;
    if (d !== 32'd3) begin
      tests_failed++;
      $display("FAIL midcount_continue: got %0d expected 3", d);
    end
    wr(2'd0, 32'h0);
    repeat (3) tick();
    rd(2'd2, d);
    tests_run++;
    if (d !== 32'd2) begin
      tests_failed++;
      $display("FAIL midcount_freeze: got %0d expected 2", d);
    end
    // Re-enable: the new PRESET must load after two edges, proving the timer went idle.
    wr(2'd0, 32'h1);
    tick();
    rd(2'd2, d);
    tests_run++;
    if (d !== 32'd2) begin
      tests_failed++;
      $display("FAIL midcount_reload_wait: got %0d expected 2", d);
    end
    wr(2'd1, 32'd7);
    wr(2'd0, 32'h0);
    wr(2'd0, 32'h1);
    tick();
    tick();
    rd(2'd2, d);
    tests_run++;
    if (d !== 32'd7) begin
      tests_failed++;
      $display("FAIL midcount_reload_value: got %0d expected 7", d);
    end
  endtask

  task automatic test_regaccess();
    logic [31:0] d;
    apply_reset();
    wr(2'd1, 32'h1234_5678);
    wr(2'd0, 32'h4);
    wr(2'd2, 32'hDEAD_BEEF);
    wr(2'd3, 32'hCAFE_F00D);
    rd(2'd0, d);
    tests_run++;
    if (d !== 32'h4) begin
      tests_failed++;
      $display("FAIL regaccess_ctrl: got %h expected %h", d, 32'h4);
    end
    rd(2'd1, d);
    tests_run++;
    if (d !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL regaccess_preset: got %h expected %h", d, 32'h1234_5678);
    end
    rd(2'd2, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL regaccess_count_ro: got %h expected %h", d, 32'h0);
    end
    rd(2'd3, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL regaccess_reserved: got %h expected %h", d, 32'h0);
    end
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, d);
    tests_run++;
    if (d !== 32'hF) begin
      tests_failed++;
      $display("FAIL regaccess_ctrl_mask: got %h expected %h", d, 32'hF);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic        we;
    logic [1:0]  a;
    logic [31:0] din;
    logic [31:0] exp_d;
    apply_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        rd(k[1:0], d);
        case (k)
          0: exp_d = {28'd0, m_ctrl};
          1: exp_d = m_preset;
          2: exp_d = m_count;
          default: exp_d = 32'd0;
        endcase
        tests_run++;
        if (d !== exp_d) begin
          tests_failed++;
          $display("FAIL random_dout[%0d]_cyc%0d: got %h expected %h", k, cyc, d, exp_d);
        end
      end
      tests_run++;
      if (IRQ !== (m_ctrl[3] & m_flag)) begin
        tests_failed++;
        $display("FAIL random_irq_cyc%0d: got %b expected %b", cyc, IRQ, m_ctrl[3] & m_flag);
      end
      we = ($urandom_range(0, 3) == 0);
      a  = 2'($urandom_range(0, 3));
      if (a == 2'd1) din = 32'($urandom_range(0, 6));
      else begin
        din    = $urandom;
        din[0] = ($urandom_range(0, 3) != 0);
      end
      model_step(we, a, din);
      Addr = a;
      WE   = we;
      Din  = din;
      @(posedge clk);
      #1;
      WE = 1'b0;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = 2'd0;
    Din   = 32'd0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_mask_off();
    test_midcount();
    test_regaccess();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
